fir_out_requant: RTL and testbench

Output stage downstream of the 5-tap symmetric TDF FIR filter. Consumes the filter's free-running 32-bit `yn` stream and re-times a sample strobe to match the filter latency. Drops warm-up outputs, optionally decimates, rounds and saturates to 16 bits, and buffers results in a small FIFO behind a valid/ready handshake for the sink (DAC formatter / capture logic).

---
 rtl/fir_out_requant.sv | 146 ++++++++++++++
 tb/tb_fir_out_requant.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant.sv
// Output stage for the 5-tap FIR: aligns a sample strobe to the filter latency,
// drops warm-up samples, decimates, rounds/saturates and queues results for the sink.
module fir_out_requant #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int LAT    = 3,
  parameter int WARMUP = 4,
  parameter int DECIM  = 1,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x_valid,
  input  logic [IN_W-1:0]          yn,
  output logic [OUT_W-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              sat_count,
  input  logic                     clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(WARMUP + 2);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);
  localparam logic [PW-1:0] PH_MAX   = PW'(DECIM - 1);

  // Rounding constant is half an output LSB; zero when no shift is applied.
  localparam logic [IN_W+1:0]        RND_X = (IN_W + 2)'(1) << SHIFT;
  localparam logic signed [IN_W:0]   RND   = $signed(RND_X[IN_W+1:1]);
  localparam logic signed [IN_W:0]   MAXV  = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0]   MINV  = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [15:0]      sat_q, sat_d;
  logic             stage_v_q, stage_v_d;
  logic [OUT_W-1:0] stage_data_q, stage_data_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [OUT_W-1:0] fifo_mem [DEPTH];

  logic                   v_a;
  logic                   keep;
  logic signed [IN_W:0]   ext, sum, r;
  logic                   sat_hi, sat_lo;
  logic [OUT_W-1:0]       q;
  logic                   full, empty, pop, wr_en, drop;

  assign v_a = vpipe_q[LAT-1];

  always_comb begin
    vpipe_d = LAT'({vpipe_q, x_valid});
    warm_d  = warm_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (v_a) begin
      if (warm_q < WARM_MAX) begin
        warm_d = warm_q + 1'b1;
      end else begin
        keep    = (phase_q == '0);
        phase_d = (phase_q == PH_MAX) ? '0 : phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    ext    = $signed({yn[IN_W-1], yn});
    sum    = ext + RND;
    r      = sum >>> SHIFT;
    sat_hi = (r > MAXV);
    sat_lo = (r < MINV);
    if (sat_hi)      q = MAXV[OUT_W-1:0];
    else if (sat_lo) q = MINV[OUT_W-1:0];
    else             q = r[OUT_W-1:0];
  end

  // A clear on the same edge wins, so a coincident saturation event is not counted.
  always_comb begin
    sat_d = sat_q;
    if (clear_flags)                                  sat_d = '0;
    else if (keep && (sat_hi || sat_lo) && sat_q != 16'hFFFF) sat_d = sat_q + 1'b1;
    stage_v_d    = keep;
    stage_data_d = keep ? q : stage_data_q;
  end

  always_comb begin
    full       = (level_q == LW'(DEPTH));
    empty      = (level_q == '0);
    pop        = m_ready && !empty;
    wr_en      = stage_v_q && (!full || pop);
    drop       = stage_v_q && full && !pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q + LW'(wr_en) - LW'(pop);
    overflow_d = overflow_q;
    if (clear_flags) overflow_d = 1'b0;
    else if (drop)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vpipe_q      <= '0;
      warm_q       <= '0;
      phase_q      <= '0;
      sat_q        <= '0;
      stage_v_q    <= 1'b0;
      stage_data_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      vpipe_q      <= vpipe_d;
      warm_q       <= warm_d;
      phase_q      <= phase_d;
      sat_q        <= sat_d;
      stage_v_q    <= stage_v_d;
      stage_data_q <= stage_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= stage_data_q;
  end

  assign m_valid    = !empty;
  assign m_data     = empty ? '0 : fifo_mem[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign sat_count  = sat_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: DECIM=1 and DECIM=2 instances share stimulus and are
// each compared every cycle against a queue-based reference of the output stage.
module tb_fir_out_requant;

  localparam int LAT    = 3;
  localparam int WARMUP = 4;
  localparam int DEPTH  = 8;
  localparam int SHIFT  = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0;
  logic [31:0] yn = '0;
  logic        m_ready = 1'b0;
  logic        clear_flags = 1'b0;

  logic [15:0] a_m_data, b_m_data;
  logic        a_m_valid, b_m_valid;
  logic [3:0]  a_fifo_level, b_fifo_level;
  logic        a_overflow, b_overflow;
  logic [15:0] a_sat_count, b_sat_count;

  int errors = 0;
  int checks = 0;

  // Reference state, index 0 = DECIM 1, index 1 = DECIM 2.
  bit          vhist [2][$];
  logic [15:0] mfifo [2][$];
  int          warm [2];
  int          phase [2];
  bit          stg_v [2];
  logic [15:0] stg_d [2];
  bit          ovf [2];
  int          satc [2];

  always #5 clk = ~clk;

  fir_out_requant #(.DECIM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .yn(yn),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(m_ready),
    .fifo_level(a_fifo_level), .overflow(a_overflow), .sat_count(a_sat_count),
    .clear_flags(clear_flags)
  );

  fir_out_requant #(.DECIM(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .yn(yn),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(m_ready),
    .fifo_level(b_fifo_level), .overflow(b_overflow), .sat_count(b_sat_count),
    .clear_flags(clear_flags)
  );

  task automatic model_edge(input int i, input int decim);
    bit          va, keep, sat, pop, drop;
    longint      r;
    logic [15:0] qv;
    if (!rst_n) begin
      vhist[i] = {};
      repeat (LAT) vhist[i].push_back(1'b0);
      mfifo[i] = {};
      warm[i] = 0; phase[i] = 0; stg_v[i] = 0; stg_d[i] = '0; ovf[i] = 0; satc[i] = 0;
    end else begin
      va = vhist[i].pop_front();
      vhist[i].push_back(x_valid);
      keep = 0;
      if (va) begin
        if (warm[i] < WARMUP) warm[i]++;
        else begin
          keep = (phase[i] == 0);
          phase[i] = (phase[i] + 1) % decim;
        end
      end
      r = (longint'($signed(yn)) + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      sat = (r > 32767) || (r < -32768);
      if (r > 32767)       qv = 16'h7FFF;
      else if (r < -32768) qv = 16'h8000;
      else                 qv = r[15:0];
      pop  = (mfifo[i].size() > 0) && m_ready;
      drop = 0;
      if (pop) void'(mfifo[i].pop_front());
      if (stg_v[i]) begin
        if (mfifo[i].size() < DEPTH) mfifo[i].push_back(stg_d[i]);
        else drop = 1;
      end
      if (clear_flags) ovf[i] = 0;
      else if (drop)   ovf[i] = 1;
      if (clear_flags) satc[i] = 0;
      else if (keep && sat && satc[i] < 65535) satc[i]++;
      stg_v[i] = keep;
      if (keep) stg_d[i] = qv;
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return (mfifo[i].size() > 0) ? {16'h0, mfifo[i][0]} : 32'h0;
  endfunction

  task automatic check_output();
    check_val("a_valid", {31'h0, a_m_valid}, {31'h0, mfifo[0].size() > 0});
    check_val("a_data", {16'h0, a_m_data}, exp_data(0));
    check_val("a_level", {28'h0, a_fifo_level}, 32'(mfifo[0].size()));
    check_val("a_ovf", {31'h0, a_overflow}, {31'h0, ovf[0]});
    check_val("a_satc", {16'h0, a_sat_count}, 32'(satc[0]));
    check_val("b_valid", {31'h0, b_m_valid}, {31'h0, mfifo[1].size() > 0});
    check_val("b_data", {16'h0, b_m_data}, exp_data(1));
    check_val("b_level", {28'h0, b_fifo_level}, 32'(mfifo[1].size()));
    check_val("b_ovf", {31'h0, b_overflow}, {31'h0, ovf[1]});
    check_val("b_satc", {16'h0, b_sat_count}, 32'(satc[1]));
  endtask

  // Drive inputs at the falling edge, update the reference on the rising edge, check at the next falling edge.
  task automatic apply_stimulus(input logic xv, input logic [31:0] y, input logic rdy,
                                input logic clr, input logic rst);
    x_valid = xv; yn = y; m_ready = rdy; clear_flags = clr; rst_n = ~rst;
    @(posedge clk);
    model_edge(0, 1);
    model_edge(1, 2);
    @(negedge clk);
    check_output();
  endtask

  task automatic send_one(input logic [31:0] y, input logic [15:0] exp, input string tag);
    apply_stimulus(1'b1, y, 1'b0, 1'b0, 1'b0);
    repeat (LAT + 1) apply_stimulus(1'b0, y, 1'b0, 1'b0, 1'b0);
    check_val(tag, {16'h0, a_m_data}, {16'h0, exp});
    apply_stimulus(1'b0, y, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int first_a, first_b;
    @(negedge clk);
    repeat (2) apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("rst_valid", {31'h0, a_m_valid}, 32'h0);

    $display("[TB] warm-up, continuous strobes");
    first_a = -1;
    for (int e = 0; e < 20; e++) begin
      apply_stimulus(1'b1, $urandom & 32'h0FFF_FFFF, 1'b1, 1'b0, 1'b0);
      if (first_a < 0 && a_m_valid) first_a = e;
    end
    check_val("first_valid_a", 32'(first_a), 32'd8);
    repeat (10) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] rounding and saturation");
    send_one(32'h0000_4000, 16'h0001, "rnd_pos_half");
    send_one(32'h0000_3FFF, 16'h0000, "rnd_pos_below");
    send_one(32'hFFFF_C000, 16'h0000, "rnd_neg_half");
    send_one(32'hFFFF_BFFF, 16'hFFFF, "rnd_neg_below");
    check_val("satc_zero", {16'h0, a_sat_count}, 32'd0);
    send_one(32'h4000_0000, 16'h7FFF, "sat_pos");
    send_one(32'h8000_0000, 16'h8000, "sat_neg");
    check_val("satc_two", {16'h0, a_sat_count}, 32'd2);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_val("satc_cleared", {16'h0, a_sat_count}, 32'd0);

    $display("[TB] backpressure");
    for (int i = 0; i < 14; i++)
      apply_stimulus(i < 10, (i >= 3 && i < 13) ? 32'(i - 2) << 15 : 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("bp_level", {28'h0, a_fifo_level}, 32'd8);
    check_val("bp_ovf", {31'h0, a_overflow}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      check_val("bp_order", {16'h0, a_m_data}, 32'(k));
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    check_val("bp_drained", {31'h0, a_m_valid}, 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    $display("[TB] full with simultaneous pop");
    for (int i = 0; i < 12; i++)
      apply_stimulus(i < 8, (i >= 3) ? 32'(i + 18) << 15 : 32'h0, 1'b0, 1'b0, 1'b0);
    check_val("full_level", {28'h0, a_fifo_level}, 32'd8);
    for (int j = 0; j < 5; j++)
      apply_stimulus(j == 0, 32'd29 << 15, j == 4, 1'b0, 1'b0);
    check_val("fullpop_level", {28'h0, a_fifo_level}, 32'd8);
    check_val("fullpop_ovf", {31'h0, a_overflow}, 32'd0);
    for (int k = 22; k <= 29; k++) begin
      check_val("fullpop_order", {16'h0, a_m_data}, 32'(k));
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end

    $display("[TB] decimation and mid-stream reset");
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int e = 0; e < 11; e++) begin
      apply_stimulus(1'b1, 32'(e + 100) << 15, 1'b1, 1'b0, 1'b0);
      if (e == 8) begin
        check_val("dec_a_first", {16'h0, a_m_data}, 32'd107);
        check_val("dec_b_first", {16'h0, b_m_data}, 32'd107);
      end
      if (e == 9) begin
        check_val("dec_a_second", {16'h0, a_m_data}, 32'd108);
        check_val("dec_b_gap", {31'h0, b_m_valid}, 32'd0);
      end
      if (e == 10) check_val("dec_b_second", {16'h0, b_m_data}, 32'd109);
    end
    for (int e = 11; e < 30 && mfifo[1].size() < 3; e++)
      apply_stimulus(1'b1, 32'(e + 100) << 15, 1'b0, 1'b0, 1'b0);
    check_val("dec_b_queued", {28'h0, b_fifo_level}, 32'd3);
    apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    check_val("rst_b_valid", {31'h0, b_m_valid}, 32'd0);
    check_val("rst_b_data", {16'h0, b_m_data}, 32'd0);
    check_val("rst_b_level", {28'h0, b_fifo_level}, 32'd0);
    first_a = -1;
    first_b = -1;
    for (int e = 0; e < 14; e++) begin
      apply_stimulus(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
      if (first_a < 0 && a_m_valid) first_a = e;
      if (first_b < 0 && b_m_valid) first_b = e;
    end
    check_val("rewarm_a", 32'(first_a), 32'd8);
    check_val("rewarm_b", 32'(first_b), 32'd8);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++)
      apply_stimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
